// File: rtl/lights_out_button_frontend_pkg.sv
// Shared definitions for the lights-out board: cell count, index width and cell names.
// Used by the button frontend, the game core and the field driver.
package lights_out_pkg;

    localparam int N_CELLS    = 9;
    localparam int CELL_IDX_W = 4;

    typedef enum logic [CELL_IDX_W-1:0] {
        CELL_1 = 4'd0,
        CELL_2 = 4'd1,
        CELL_3 = 4'd2,
        CELL_4 = 4'd3,
        CELL_5 = 4'd4,
        CELL_6 = 4'd5,
        CELL_7 = 4'd6,
        CELL_8 = 4'd7,
        CELL_9 = 4'd8
    } cell_e;

    // (base + step) mod N_CELLS for base < N_CELLS and step <= N_CELLS.
    function automatic logic [CELL_IDX_W-1:0] wrap_cell(input logic [CELL_IDX_W-1:0] base,
                                                        input int step);
        int s;
        s = int'(base) + step;
        if (s >= N_CELLS) s = s - N_CELLS;
        return CELL_IDX_W'(s);
    endfunction

endpackage

// File: rtl/lights_out_button_frontend_if.sv
// Press-event handshake between the button frontend (master) and the game core (slave).
interface lights_out_button_frontend_if;
    import lights_out_pkg::*;

    logic                  press_valid;
    logic                  press_ready;
    logic [CELL_IDX_W-1:0] press_idx;
    logic [N_CELLS-1:0]    press_mask;

    modport master (output press_valid, press_idx, press_mask, input press_ready);
    modport slave  (input press_valid, press_idx, press_mask, output press_ready);

endinterface

// File: rtl/lights_out_button_frontend_debounce.sv
// One button: two-flop synchroniser, stable-count debouncer and rising-edge detect.
module lo_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the synchronised input matches the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
            else                                       cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (ena_i) begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;

endmodule

// File: rtl/lights_out_button_frontend.sv
// Lights-out input frontend: debounced buttons feed a pending bitmap that a round-robin
// arbiter drains one press event at a time into a valid/ready output register.
module lights_out_button_frontend
    import lights_out_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena_i,
    input  logic [N_CELLS-1:0]   btn_raw_i,
    output logic [N_CELLS-1:0]   btn_level_o,
    output logic                 overrun_o,
    lights_out_button_frontend_if.master press
);

    localparam logic [N_CELLS-1:0] ONE_HOT0 = N_CELLS'(1);

    logic [N_CELLS-1:0]    rise;
    logic [N_CELLS-1:0]    pending_q;
    logic [N_CELLS-1:0]    pending_d;
    logic [N_CELLS-1:0]    clear;
    logic [CELL_IDX_W-1:0] rr_q;
    logic [CELL_IDX_W-1:0] rr_d;
    logic                  valid_q;
    logic                  valid_d;
    logic [CELL_IDX_W-1:0] idx_q;
    logic [CELL_IDX_W-1:0] idx_d;
    logic [N_CELLS-1:0]    mask_q;
    logic [N_CELLS-1:0]    mask_d;
    logic                  overrun_q;
    logic                  overrun_d;
    logic [CELL_IDX_W-1:0] cand;
    logic [CELL_IDX_W-1:0] sel;
    logic                  found;
    logic                  take;

    for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
        lo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena_i   (ena_i),
            .raw_i   (btn_raw_i[i]),
            .level_o (btn_level_o[i]),
            .rise_o  (rise[i])
        );
    end

    // Round-robin search begins one past the last issued cell.
    always_comb begin
        cand  = '0;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_CELLS; k++) begin
            cand = wrap_cell(rr_q, k);
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        take      = ena_i && (!valid_q || press.press_ready);
        clear     = (take && found) ? (ONE_HOT0 << sel) : '0;
        // A rise on a cell being issued this cycle survives as a fresh pending press.
        pending_d = (pending_q & ~clear) | rise;
        overrun_d = |(rise & pending_q & ~clear);
        valid_d   = valid_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        rr_d      = rr_q;
        if (take) begin
            valid_d = found;
            if (found) begin
                idx_d  = sel;
                mask_d = ONE_HOT0 << sel;
                rr_d   = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            rr_q      <= CELL_IDX_W'(N_CELLS - 1);
            valid_q   <= 1'b0;
            idx_q     <= '0;
            mask_q    <= '0;
            overrun_q <= 1'b0;
        end else if (ena_i) begin
            pending_q <= pending_d;
            rr_q      <= rr_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            overrun_q <= overrun_d;
        end else begin
            overrun_q <= 1'b0;
        end
    end

    assign press.press_valid = valid_q;
    assign press.press_idx   = idx_q;
    assign press.press_mask  = mask_q;
    assign overrun_o         = overrun_q & ena_i;

endmodule
